store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
- Store-side counterpart to the load-side immediate/data extenders in the AAI_CPU datapath.
- Takes a 32-bit register value plus a byte address and a store size (SB/SH/SW). Narrows and replicates the value onto the correct byte lanes and generates byte enables.
- Drives one request/acknowledge write transaction to data memory.
- Sits between the MEM-stage control and the data-memory port. Flags misaligned stores and memory timeouts instead of issuing them.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_ack before aborting. Legal range 1..255; 8-bit counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- st_valid  in  1  store request valid
- st_ready  out  1  unit can accept a request (high only in IDLE)
- st_addr  in  32  byte address
- st_data  in  32  register value to store; low bits used for SB/SH
- st_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- mem_req  out  1  write request to memory
- mem_addr  out  32  word address: {st_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables; bit i covers wdata[8i+7:8i]
- mem_ack  in  1  memory accepted the write (sampled only while mem_req=1)
- done  out  1  one-cycle pulse: store completed
- align_err  out  1  one-cycle pulse: store rejected as misaligned or reserved size
- timeout_err  out  1  one-cycle pulse: store aborted, no ack within TIMEOUT

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE, regardless of state, including mid-REQ.
  - mem_req, done, align_err, timeout_err, mem_be, mem_addr, mem_wdata, and the timeout counter all go to 0.
  - st_ready=1 on the first cycle after reset.
- All outputs are registered. Little-endian lane mapping.
- FSM states: IDLE, REQ.
- IDLE:
  - st_ready=1. A request is accepted when st_valid=1 at an edge.
  - If the request is misaligned, no memory access is made. The state stays IDLE and align_err=1 for exactly the next cycle. Misaligned means any of:
    - half with addr[0]=1
    - word with addr[1:0]!=00
    - size=11
  - Otherwise, from the next cycle: state=REQ, mem_req=1, and mem_addr/mem_wdata/mem_be are loaded. The counter is cleared to 0.
- Lane rules:
  - Byte: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0].
  - Half: wdata={2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata=data, be=1111.
- REQ:
  - st_ready=0. mem_req, mem_addr, mem_wdata and mem_be are held stable until the transaction ends.
  - The counter increments each cycle mem_ack=0.
  - If mem_ack=1: the next cycle has state=IDLE, mem_req=0, mem_be=0 and done=1 (one cycle).
  - Else, if the counter equals TIMEOUT-1: the next cycle has state=IDLE, mem_req=0, mem_be=0 and timeout_err=1 (one cycle).
  - If mem_ack=1 arrives on the same cycle the timeout would fire, ack wins (done, no timeout_err).
- Latency: accept at edge N gives mem_req=1 from N+1. Ack sampled at edge K gives done=1 and st_ready=1 during K+1.
- Back-to-back: a new request may be accepted on the edge ending the done, align_err or timeout_err cycle. Pulses never stretch.
- mem_ack while in IDLE is ignored.
- At most one of done/align_err/timeout_err is high in any cycle.

Test Plan:
- Reset then SW: addr=0x00001004, data=0xDEADBEEF, ack held 1 -> mem_req=1 for exactly one cycle, addr=0x00001004, be=1111, wdata=0xDEADBEEF; done pulses the next cycle.
- SB sweep: data=0x000000A5, addr[1:0]=0..3, ack after 2 cycles -> wdata=0xA5A5A5A5 each time; be=0001, 0010, 0100, 1000; mem_req high for exactly 3 cycles each.
- SH at addr=0x...02 with data=0x12345678 -> wdata=0x56785678, be=1100. SH at 0x...01 -> no mem_req, align_err=1 for one cycle. SW at 0x...02 and size=11 -> align_err pulses, no mem_req.
- TIMEOUT=4, mem_ack held 0 -> mem_req high for 4 cycles, then timeout_err pulses once, st_ready=1. Variant: ack on the 4th cycle -> done pulses, timeout_err stays 0.
- Back-to-back: two SW requests with st_valid held high, ack immediate -> second request accepted in the done cycle, with one idle cycle on mem_req between the transactions.
- rst_n=0 during REQ -> next cycle mem_req=0, mem_be=0, no done/timeout_err pulse, st_ready=1. A later store completes normally.

Source files
------------

// File: rtl/store_narrow_unit_if.sv
// Store request / data-memory write bundle for store_narrow_unit.
// slave: the narrowing unit itself. master: the CPU MEM stage plus memory model.
interface store_narrow_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        align_err;
  logic        timeout_err;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           done, align_err, timeout_err
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           done, align_err, timeout_err
  );
endinterface

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: replicates SB/SH/SW data onto little-endian byte lanes,
// generates byte enables and runs one req/ack write to data memory. Misaligned
// or reserved-size stores are rejected with align_err; a missing ack aborts the
// write after TIMEOUT cycles with timeout_err. All outputs are registered.
module store_narrow_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  store_narrow_unit_if.slave  sn
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_st_ready;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_done;
  logic        r_align_err;
  logic        r_timeout_err;
  logic [7:0]  r_cnt;

  state_t      w_state_nxt;
  logic        w_mem_req_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] w_mem_wdata_nxt;
  logic [3:0]  w_mem_be_nxt;
  logic        w_done_nxt;
  logic        w_align_err_nxt;
  logic        w_timeout_err_nxt;
  logic [7:0]  w_cnt_nxt;

  logic        w_misalign;
  logic [3:0]  w_lane_be;
  logic [31:0] w_lane_wdata;

  // Lane placement and alignment check for the presented request.
  always_comb begin
    w_misalign   = 1'b0;
    w_lane_be    = '0;
    w_lane_wdata = '0;
    case (sn.st_size)
      2'b00: begin
        w_lane_be    = 4'b0001 << sn.st_addr[1:0];
        w_lane_wdata = {4{sn.st_data[7:0]}};
      end
      2'b01: begin
        w_misalign   = sn.st_addr[0];
        w_lane_be    = sn.st_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{sn.st_data[15:0]}};
      end
      2'b10: begin
        w_misalign   = |sn.st_addr[1:0];
        w_lane_be    = '1;
        w_lane_wdata = sn.st_data;
      end
      default: begin
        w_misalign   = 1'b1;
      end
    endcase
  end

  // Next-state and next-output logic; bus fields hold unless explicitly changed.
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_mem_be_nxt      = r_mem_be;
    w_cnt_nxt         = r_cnt;
    w_done_nxt        = 1'b0;
    w_align_err_nxt   = 1'b0;
    w_timeout_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sn.st_valid) begin
          if (w_misalign) begin
            w_align_err_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_REQ;
            w_mem_req_nxt   = 1'b1;
            w_mem_addr_nxt  = {sn.st_addr[31:2], 2'b00};
            w_mem_wdata_nxt = w_lane_wdata;
            w_mem_be_nxt    = w_lane_be;
            w_cnt_nxt       = '0;
          end
        end
      end
      S_REQ: begin
        // Ack is tested first so it wins over a timeout landing on the same edge.
        if (sn.mem_ack) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_be_nxt  = '0;
          w_cnt_nxt     = '0;
          w_done_nxt    = 1'b1;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt       = S_IDLE;
          w_mem_req_nxt     = 1'b0;
          w_mem_be_nxt      = '0;
          w_cnt_nxt         = '0;
          w_timeout_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_st_ready    <= 1'b1;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_done        <= 1'b0;
      r_align_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_st_ready    <= (w_state_nxt == S_IDLE);
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_done        <= w_done_nxt;
      r_align_err   <= w_align_err_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign sn.st_ready    = r_st_ready;
  assign sn.mem_req     = r_mem_req;
  assign sn.mem_addr    = r_mem_addr;
  assign sn.mem_wdata   = r_mem_wdata;
  assign sn.mem_be      = r_mem_be;
  assign sn.done        = r_done;
  assign sn.align_err   = r_align_err;
  assign sn.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit (TIMEOUT=4): a vector table,
// hand-written multi-cycle sequences and randomized stores against a model.
module tb_store_narrow_unit;

  localparam int unsigned TMO = 4;

  logic clk;
  logic rst_n;
  store_narrow_unit_if sif ();

  store_narrow_unit #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sn    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Result kinds: 0 = done, 1 = align_err, 2 = timeout_err.
  typedef struct {
    string       name;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_delay;   // ack raised on req cycle ack_delay+1
    int          exp_kind;
    int          exp_nreq;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: lanes from byte count and offset, replication by byte index modulo size.
  task automatic model(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                       output bit mis, output logic [3:0] be, output logic [31:0] wd);
    int nb;
    int off;
    logic [31:0] d;
    d   = data;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    mis = (size == 2'd3) || ((addr % nb) != 0);
    be  = 4'(((1 << nb) - 1) << off);
    wd  = '0;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % nb) +: 8];
  endtask

  task automatic do_txn(input string name, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] data, input int ack_delay, input int exp_kind,
                        input int exp_nreq, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int nreq;
    int unstable;
    int waited;
    bit ended;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    nreq = 0; unstable = 0; waited = 0; ended = 0;
    a0 = '0; w0 = '0; b0 = '0;
    @(negedge clk);
    while (!sif.st_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!sif.st_ready) check({name, "_ready_wait"}, 32'(sif.st_ready), 32'd1);
    sif.st_valid = 1'b1;
    sif.st_size  = size;
    sif.st_addr  = addr;
    sif.st_data  = data;
    @(posedge clk);
    @(negedge clk);
    sif.st_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!sif.mem_req) begin
        ended = 1;
        break;
      end
      nreq++;
      if (nreq == 1) begin
        a0 = sif.mem_addr; w0 = sif.mem_wdata; b0 = sif.mem_be;
        check({name, "_ready_low"}, 32'(sif.st_ready), 32'd0);
      end else if (sif.mem_addr !== a0 || sif.mem_wdata !== w0 || sif.mem_be !== b0) begin
        unstable++;
      end
      sif.mem_ack = (nreq == ack_delay + 1);
      @(negedge clk);
    end
    sif.mem_ack = 1'b0;
    check({name, "_ended"}, 32'(ended), 32'd1);
    check({name, "_nreq"}, 32'(nreq), 32'(exp_nreq));
    check({name, "_flags"}, {29'd0, sif.done, sif.align_err, sif.timeout_err},
          (exp_kind == 0) ? 32'd4 : (exp_kind == 1) ? 32'd2 : 32'd1);
    check({name, "_ready_end"}, 32'(sif.st_ready), 32'd1);
    check({name, "_be_end"}, 32'(sif.mem_be), 32'd0);
    if (exp_nreq > 0) begin
      check({name, "_addr"}, a0, addr & ~32'd3);
      check({name, "_wdata"}, w0, exp_wd);
      check({name, "_be"}, 32'(b0), 32'(exp_be));
      check({name, "_stable"}, 32'(unstable), 32'd0);
    end
    @(negedge clk);
    check({name, "_pulse_once"}, {29'd0, sif.done, sif.align_err, sif.timeout_err}, 32'd0);
    check({name, "_no_req_after"}, 32'(sif.mem_req), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.st_valid = 1'b0;
    sif.st_addr  = '0;
    sif.st_data  = '0;
    sif.st_size  = '0;
    sif.mem_ack  = 1'b0;
    rst_n = 1'b0;

    vecs.push_back('{"sw_1004",  2'd2, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF});
    vecs.push_back('{"sb_0",     2'd0, 32'h0000_2000, 32'h0000_00A5, 2, 0, 3, 4'b0001, 32'hA5A5_A5A5});
    vecs.push_back('{"sb_1",     2'd0, 32'h0000_2001, 32'h0000_00A5, 2, 0, 3, 4'b0010, 32'hA5A5_A5A5});
    vecs.push_back('{"sb_2",     2'd0, 32'h0000_2002, 32'h0000_00A5, 2, 0, 3, 4'b0100, 32'hA5A5_A5A5});
    vecs.push_back('{"sb_3",     2'd0, 32'h0000_2003, 32'h0000_00A5, 2, 0, 3, 4'b1000, 32'hA5A5_A5A5});
    vecs.push_back('{"sh_2",     2'd1, 32'h0000_3002, 32'h1234_5678, 1, 0, 2, 4'b1100, 32'h5678_5678});
    vecs.push_back('{"sh_0",     2'd1, 32'h0000_5000, 32'hCAFE_BABE, 0, 0, 1, 4'b0011, 32'hBABE_BABE});
    vecs.push_back('{"sh_mis",   2'd1, 32'h0000_3001, 32'h1234_5678, 0, 1, 0, 4'b0000, 32'h0});
    vecs.push_back('{"sw_mis",   2'd2, 32'h0000_3002, 32'h1234_5678, 0, 1, 0, 4'b0000, 32'h0});
    vecs.push_back('{"rsv_size", 2'd3, 32'h0000_3000, 32'h1234_5678, 0, 1, 0, 4'b0000, 32'h0});
    vecs.push_back('{"timeout",  2'd2, 32'h0000_4000, 32'h1122_3344, 9, 2, 4, 4'b1111, 32'h1122_3344});
    vecs.push_back('{"ack_last", 2'd2, 32'h0000_4008, 32'h5566_7788, 3, 0, 4, 4'b1111, 32'h5566_7788});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(sif.st_ready), 32'd1);
    check("rst_req",   32'(sif.mem_req), 32'd0);
    check("rst_be",    32'(sif.mem_be), 32'd0);
    check("rst_addr",  sif.mem_addr, 32'd0);
    check("rst_wdata", sif.mem_wdata, 32'd0);
    check("rst_flags", {29'd0, sif.done, sif.align_err, sif.timeout_err}, 32'd0);

    foreach (vecs[i])
      do_txn(vecs[i].name, vecs[i].size, vecs[i].addr, vecs[i].data, vecs[i].ack_delay,
             vecs[i].exp_kind, vecs[i].exp_nreq, vecs[i].exp_be, vecs[i].exp_wdata);

    // mem_ack while idle must not cause anything.
    sif.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ack_req",  32'(sif.mem_req), 32'd0);
      check("idle_ack_done", 32'(sif.done), 32'd0);
    end
    sif.mem_ack = 1'b0;

    // Back-to-back SW with st_valid held and ack immediate.
    @(negedge clk);
    sif.st_valid = 1'b1; sif.st_size = 2'd2;
    sif.st_addr = 32'h0000_7000; sif.st_data = 32'hAAAA_0001; sif.mem_ack = 1'b1;
    @(negedge clk);
    check("b2b_req1",  32'(sif.mem_req), 32'd1);
    check("b2b_addr1", sif.mem_addr, 32'h0000_7000);
    sif.st_addr = 32'h0000_7004; sif.st_data = 32'hBBBB_0002;
    @(negedge clk);
    check("b2b_done1", {30'd0, sif.done, sif.mem_req}, 32'd2);
    @(negedge clk);
    check("b2b_req2",   32'(sif.mem_req), 32'd1);
    check("b2b_addr2",  sif.mem_addr, 32'h0000_7004);
    check("b2b_wdata2", sif.mem_wdata, 32'hBBBB_0002);
    check("b2b_done_drop", 32'(sif.done), 32'd0);
    @(negedge clk);
    check("b2b_done2", {30'd0, sif.done, sif.mem_req}, 32'd2);
    sif.st_valid = 1'b0; sif.mem_ack = 1'b0;
    @(negedge clk);
    check("b2b_idle", {30'd0, sif.done, sif.mem_req}, 32'd0);

    // Reset in the middle of a request.
    sif.st_valid = 1'b1; sif.st_size = 2'd2;
    sif.st_addr = 32'h0000_6000; sif.st_data = 32'h0BAD_F00D;
    @(negedge clk);
    sif.st_valid = 1'b0;
    check("mrst_req_on", 32'(sif.mem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_req", 32'(sif.mem_req), 32'd0);
    check("mrst_be",  32'(sif.mem_be), 32'd0);
    check("mrst_ready", 32'(sif.st_ready), 32'd1);
    check("mrst_flags", {29'd0, sif.done, sif.align_err, sif.timeout_err}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mrst_quiet", {28'd0, sif.mem_req, sif.done, sif.align_err, sif.timeout_err}, 32'd0);
    end
    do_txn("post_rst", 2'd0, 32'h0000_6003, 32'h0000_0042, 1, 0, 2, 4'b1000, 32'h4242_4242);

    // Randomized stores against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  sz;
      logic [31:0] ad, dt, wd;
      logic [3:0]  be;
      bit          mis;
      int          dly, kind, nr;
      sz  = 2'($urandom_range(0, 3));
      ad  = $urandom;
      dt  = $urandom;
      dly = $urandom_range(0, 6);
      model(sz, ad, dt, mis, be, wd);
      if (mis) begin
        kind = 1; nr = 0;
      end else if (dly + 1 <= TMO) begin
        kind = 0; nr = dly + 1;
      end else begin
        kind = 2; nr = TMO;
      end
      do_txn($sformatf("rnd%0d", i), sz, ad, dt, dly, kind, nr, be, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
